// File: rtl/aes_round_key_cache.sv
// AES-128 round key cache: sequences the key expander once per cipher key, captures all
// ROUNDS+1 round keys, then serves random-access reads with one-cycle latency.
module aes_round_key_cache #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 10,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] exp_key,
  output logic             exp_warm_key,
  input  logic [KEY_W-1:0] exp_round_key,
  output logic             cache_ready,
  output logic             busy,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid,
  output logic             rd_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_READY
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_slot [0:ROUNDS];
  logic [KEY_W-1:0] r_exp_key;
  logic [KEY_W-1:0] r_rd_key;
  logic             r_rd_valid;
  logic             r_rd_err;
  logic             w_accept;
  logic             w_rd_ok;

  assign key_ready    = (r_state == S_IDLE) || (r_state == S_READY);
  assign busy         = (r_state == S_LOAD) || (r_state == S_WARM);
  assign cache_ready  = (r_state == S_READY);
  assign exp_warm_key = (r_state == S_WARM) && (r_cnt < LAST_IDX);
  assign exp_key      = r_exp_key;
  assign rd_key       = r_rd_key;
  assign rd_valid     = r_rd_valid;
  assign rd_err       = r_rd_err;

  assign w_accept = key_valid && key_ready;
  // A read in the accept cycle still sees READY and the old slot 0.
  assign w_rd_ok  = rd_en && cache_ready && (rd_idx <= LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_WARM;
      S_WARM:  if (r_cnt == LAST_IDX) w_state_nxt = S_READY;
      S_READY: if (w_accept) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_exp_key <= '0;
      for (int unsigned i = 0; i < ROUNDS + 1; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_slot[0] <= key_in;
        r_exp_key <= key_in;
      end
      case (r_state)
        S_LOAD: r_cnt <= IDX_W'(1);
        S_WARM: begin
          r_slot[r_cnt] <= exp_round_key;
          r_cnt         <= (r_cnt == LAST_IDX) ? '0 : r_cnt + IDX_W'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_key   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_err   <= rd_en && !w_rd_ok;
      if (w_rd_ok) begin
        r_rd_key <= r_slot[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_cache.sv
// Bench for aes_round_key_cache: behavioural AES-128 expander model drives the expander
// interface; a full key-schedule model predicts every cached round key.
module tb_aes_round_key_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] exp_key;
  logic         exp_warm_key;
  logic [127:0] exp_round_key;
  logic         cache_ready;
  logic         busy;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;

  aes_round_key_cache #(.KEY_W(128), .ROUNDS(10), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .exp_key(exp_key), .exp_warm_key(exp_warm_key), .exp_round_key(exp_round_key),
    .cache_ready(cache_ready), .busy(busy), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 1; i < r; i++) v = gmul(v, 8'h02);
    return v;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
    logic [31:0] w3, rot, sub, t, n0, n1, n2, n3;
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
    t   = sub ^ {rcon(r), 24'h0};
    n0  = k[127:96] ^ t;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Expander model: warm_key low restarts from exp_key, high advances one round per cycle.
  int exp_r = 0;
  always @(posedge clk) begin
    if (!exp_warm_key) begin
      exp_round_key <= next_rk(exp_key, 1);
      exp_r         <= 1;
    end else begin
      exp_round_key <= next_rk(exp_round_key, exp_r + 1);
      exp_r         <= exp_r + 1;
    end
  end

  int           checks = 0;
  int           errors = 0;
  logic [127:0] sched [0:10];
  logic [127:0] last_rd = '0;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic build_model(input logic [127:0] k);
    sched[0] = k;
    for (int r = 1; r <= 10; r++) sched[r] = next_rk(sched[r-1], r);
  endtask

  task automatic chk_reset;
    chk("rst_ctrl", 128'({key_ready, cache_ready, busy, exp_warm_key, rd_valid, rd_err}),
        128'(6'b100000));
    chk("rst_exp_key", exp_key, '0);
    chk("rst_rd_key", rd_key, '0);
  endtask

  // Wait until the cache fills; cyc counts cycles since the accept cycle.
  task automatic wait_ready(input int start, output int cyc, output int warm, output int bsy);
    cyc = start; warm = 0; bsy = 0;
    while (!cache_ready && cyc < 40) begin
      if (exp_warm_key) warm++;
      if (busy && !key_ready) bsy++;
      step;
      cyc++;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    int cyc, warm, bsy;
    key_in = k; key_valid = 1'b1;
    step;
    key_valid = 1'b0;
    build_model(k);
    chk("exp_key_loaded", exp_key, k);
    wait_ready(1, cyc, warm, bsy);
    chk("fill_latency", 128'(cyc), 128'(12));
    chk("warm_cycles", 128'(warm), 128'(9));
    chk("busy_cycles", 128'(bsy), 128'(11));
  endtask

  task automatic rd_check(input int idx);
    rd_en = 1'b1; rd_idx = 4'(idx);
    step;
    rd_en = 1'b0;
    if (idx <= 10) begin
      chk("rd_flags_ok", 128'({rd_valid, rd_err}), 128'(2'b10));
      chk("rd_data", rd_key, sched[idx]);
      last_rd = sched[idx];
    end else begin
      chk("rd_flags_err", 128'({rd_valid, rd_err}), 128'(2'b01));
      chk("rd_err_hold", rd_key, last_rd);
    end
  endtask

  task automatic sweep;
    for (int i = 10; i >= 0; i--) begin
      rd_en = 1'b1; rd_idx = 4'(i);
      step;
      chk("sweep_flags", 128'({rd_valid, rd_err}), 128'(2'b10));
      chk("sweep_data", rd_key, sched[i]);
    end
    rd_en = 1'b0;
    last_rd = sched[0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [6];
    logic [127:0] k3, k4, k5;
    int n, low, cyc, warm, bsy;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end

    vt[0] = '{K_SEQ,  10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vt[1] = '{K_SEQ,  1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vt[2] = '{K_SEQ,  0,  K_SEQ};
    vt[3] = '{K_FIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[4] = '{K_FIPS, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vt[5] = '{K_FIPS, 0,  K_FIPS};

    #1;
    chk_reset;
    repeat (2) step;
    rst = 1'b1;
    step;
    chk_reset;

    // FIPS key: fill, reverse sweep, out-of-range reads
    expand(K_FIPS);
    sweep;
    rd_check(11);
    rd_check(15);

    // Re-key in READY with a same-cycle read of index 0
    key_in = K_SEQ; key_valid = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
    step;
    key_valid = 1'b0;
    chk("rekey_old_flags", 128'({rd_valid, rd_err}), 128'(2'b10));
    chk("rekey_old_key", rd_key, K_FIPS);
    chk("rekey_cache_drop", 128'(cache_ready), 128'(0));
    last_rd = K_FIPS;
    build_model(K_SEQ);
    for (int c = 1; c <= 11; c++) begin
      rd_en = 1'b1; rd_idx = 4'(c - 1);
      step;
      chk("busy_rd_flags", 128'({rd_valid, rd_err}), 128'(2'b01));
      chk("busy_rd_hold", rd_key, last_rd);
    end
    rd_en = 1'b0;
    chk("rekey_ready_c12", 128'(cache_ready), 128'(1));

    // Known-answer table
    for (int i = 0; i < 6; i++) begin
      if (vt[i].key !== sched[0]) expand(vt[i].key);
      rd_en = 1'b1; rd_idx = 4'(vt[i].idx);
      step;
      rd_en = 1'b0;
      chk("table_flags", 128'({rd_valid, rd_err}), 128'(2'b10));
      chk("table_data", rd_key, vt[i].exp);
      last_rd = vt[i].exp;
    end

    // key_valid held during WARM: stalled until the cache is ready
    k3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_in = k3; key_valid = 1'b1;
    step;
    key_valid = 1'b0;
    step; step;
    key_in = k4; key_valid = 1'b1;
    n = 3; low = 0;
    while (!cache_ready && n < 40) begin
      if (!key_ready) low++;
      step;
      n++;
    end
    chk("stall_ready_cycle", 128'(n), 128'(12));
    chk("stall_kr_low", 128'(low), 128'(9));
    chk("stall_kr_c12", 128'(key_ready), 128'(1));
    step;
    key_valid = 1'b0;
    chk("stall_accept_c12", 128'({busy, cache_ready}), 128'(2'b10));
    build_model(k4);
    wait_ready(13, cyc, warm, bsy);
    chk("stall_fill_cycle", 128'(cyc), 128'(24));
    chk("stall_warm", 128'(warm), 128'(9));
    sweep;

    // Reset in C6, then a fresh expansion
    k5 = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_in = k5; key_valid = 1'b1;
    step;
    key_valid = 1'b0;
    repeat (5) step;
    rst = 1'b0;
    #1;
    chk_reset;
    step;
    rst = 1'b1;
    rd_en = 1'b1; rd_idx = 4'd0;
    step;
    rd_en = 1'b0;
    chk("post_rst_rd", 128'({rd_valid, rd_err}), 128'(2'b01));
    chk("post_rst_rd_key", rd_key, '0);
    last_rd = '0;
    expand({$urandom(), $urandom(), $urandom(), $urandom()});
    sweep;

    // Random keys and random reads (including out-of-range indices)
    for (int k = 0; k < 3; k++) begin
      expand({$urandom(), $urandom(), $urandom(), $urandom()});
      for (int j = 0; j < 20; j++) begin
        rd_check(int'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          step;
          chk("idle_flags", 128'({rd_valid, rd_err}), 128'(2'b00));
          chk("idle_hold", rd_key, last_rd);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
